// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM encodings, matrix
// idle/initial patterns and a one-hot-low row decoder.
package keypad_pkg;

    localparam logic [1:0] SCAN    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;

    localparam logic [3:0] COL_INIT = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'hF;

    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } row_dec_t;

    // Exactly one low bit yields single=1 with its index; anything else is not a single press.
    function automatic row_dec_t decode_row(input logic [3:0] r);
        row_dec_t d;
        d.single = 1'b0;
        d.idx    = 2'd0;
        case (r)
            4'b1110: begin d.single = 1'b1; d.idx = 2'd0; end
            4'b1101: begin d.single = 1'b1; d.idx = 2'd1; end
            4'b1011: begin d.single = 1'b1; d.idx = 2'd2; end
            4'b0111: begin d.single = 1'b1; d.idx = 2'd3; end
            default: begin d.single = 1'b0; d.idx = 2'd0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running clock divider: one-cycle tick every DIV clocks (first tick DIV-1
// clocks after reset). No backpressure; runs unconditionally.
module scan_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == CW'(DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: walks an active-low column, debounces press/release over
// DEBOUNCE_SCANS scan ticks, emits one-clock key_valid / key_release pulses.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keyboard_row,
    output logic [3:0] keyboard_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       key_release
);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_SCANS);

    logic          tick;
    logic [3:0]    row_s1_q, row_s_q;
    logic [1:0]    state_q, state_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    col_ptr_q, col_ptr_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;
    logic          held_q, held_d;
    logic          rel_q, rel_d;
    row_dec_t      rd;
    logic          row_idle, row_same;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign rd       = decode_row(row_s_q);
    assign row_idle = (row_s_q == ROW_IDLE);
    assign row_same = rd.single && (rd.idx == row_idx_q);
    assign cnt_inc  = cnt_q + DW'(1);

    // Column pointer and drive pattern rotate together, so col_ptr_q is the
    // column index of the key while the column is frozen.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        col_ptr_d = col_ptr_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        held_d    = held_q;
        rel_d     = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rd.single) begin
                        row_idx_d = rd.idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            valid_d = 1'b1;
                            code_d  = {rd.idx, col_ptr_q};
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d   = DW'(1);
                            state_d = CONFIRM;
                        end
                    end else begin
                        col_d     = {col_q[2:0], col_q[3]};
                        col_ptr_d = col_ptr_q + 2'd1;
                    end
                end
                CONFIRM: begin
                    if (!row_same) begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else if (cnt_inc == DB_MAX) begin
                        valid_d = 1'b1;
                        code_d  = {row_idx_q, col_ptr_q};
                        held_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (!row_idle) begin
                        cnt_d = '0;
                    end else if (cnt_inc == DB_MAX) begin
                        held_d  = 1'b0;
                        rel_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q  <= ROW_IDLE;
            row_s_q   <= ROW_IDLE;
            state_q   <= SCAN;
            col_q     <= COL_INIT;
            col_ptr_q <= 2'd0;
            row_idx_q <= 2'd0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            code_q    <= 4'd0;
            held_q    <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            row_s1_q  <= keyboard_row;
            row_s_q   <= row_s1_q;
            state_q   <= state_d;
            col_q     <= col_d;
            col_ptr_q <= col_ptr_d;
            row_idx_q <= row_idx_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            held_q    <= held_d;
            rel_q     <= rel_d;
        end
    end

    assign keyboard_col = col_q;
    assign key_valid    = valid_q;
    assign key_code     = code_q;
    assign key_held     = held_q;
    assign key_release  = rel_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3;
// a passive 4x4 switch matrix is modelled from the pressed-key mask.
module tb_keypad_matrix_scanner;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keyboard_row;
    logic [3:0] keyboard_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       key_release;
    logic [15:0] keys;   // bit r*4+c = key at row r, column c is closed

    int tests = 0;
    int fails = 0;
    int vld_cnt = 0;
    int rel_cnt = 0;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .keyboard_row (keyboard_row),
        .keyboard_col (keyboard_col),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_held     (key_held),
        .key_release  (key_release)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            keyboard_row[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !keyboard_col[c]) keyboard_row[r] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (key_valid)   vld_cnt++;
        if (key_release) rel_cnt++;
        if (!rst && (key_valid || key_release)) begin
            tests++;
            assert (!(key_valid && key_release))
                else begin fails++; $error("FAIL overlap: valid=%0b release=%0b required not both", key_valid, key_release); end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
            else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
    endtask

    initial begin
        rst  = 1'b1;
        keys = 16'h0;
        step(2);
        rst = 1'b0;
        step(6);
        chk("col_before_reset", 16'(keyboard_col), 16'hD);

        // Reset mid-scan: asynchronous, visible before the next edge
        rst = 1'b1;
        #1;
        chk("rst_col",     16'(keyboard_col), 16'hE);
        chk("rst_valid",   16'(key_valid),    16'h0);
        chk("rst_code",    16'(key_code),     16'h0);
        chk("rst_held",    16'(key_held),     16'h0);
        chk("rst_release", 16'(key_release), 16'h0);
        step(2);
        rst = 1'b0;
        step(3);  chk("scan_e3",  16'(keyboard_col), 16'hE);
        step(1);  chk("scan_e4",  16'(keyboard_col), 16'hD);
        step(4);  chk("scan_e8",  16'(keyboard_col), 16'hB);
        step(4);  chk("scan_e12", 16'(keyboard_col), 16'h7);
        step(4);  chk("scan_e16", 16'(keyboard_col), 16'hE);

        // Key row 2 col 1: matched ticks at E24, E28, E32
        keys[9] = 1'b1;
        step(8);  chk("press_col_frozen", 16'(keyboard_col), 16'hD);
                  chk("press_no_valid_yet", 16'(key_valid), 16'h0);
        step(7);  chk("press_e31_valid", 16'(key_valid), 16'h0);
        step(1);  chk("press_valid", 16'(key_valid), 16'h1);
                  chk("press_code",  16'(key_code),  16'h9);
                  chk("press_held",  16'(key_held),  16'h1);
        step(1);  chk("press_pulse_end", 16'(key_valid), 16'h0);
        step(8);  chk("press_col_held", 16'(keyboard_col), 16'hD);
                  chk("press_vld_cnt",  16'(vld_cnt), 16'd1);

        // Release with one tick of chatter: idle, pressed, idle x3
        step(3);  keys[9] = 1'b0;
        step(4);  chk("rel_idle1_held", 16'(key_held), 16'h1);
                  keys[9] = 1'b1;
        step(4);  keys[9] = 1'b0;
        step(4);  chk("rel_idle_a_held", 16'(key_held), 16'h1);
        step(4);  chk("rel_idle_b_held", 16'(key_held), 16'h1);
                  chk("rel_no_release_yet", 16'(rel_cnt), 16'd0);
        step(3);  chk("rel_e63_held", 16'(key_held), 16'h1);
        step(1);  chk("rel_pulse", 16'(key_release), 16'h1);
                  chk("rel_held_clr", 16'(key_held), 16'h0);
        step(1);  chk("rel_pulse_end", 16'(key_release), 16'h0);
        step(3);  chk("rel_scan_resumes", 16'(keyboard_col), 16'hB);
                  chk("rel_cnt_one", 16'(rel_cnt), 16'd1);

        // Rows 0 and 3 low in column 2: multi, never confirmed
        keys[2] = 1'b1; keys[14] = 1'b1;
        step(4);  chk("multi_rotates", 16'(keyboard_col), 16'h7);
        step(16); chk("multi_col", 16'(keyboard_col), 16'h7);
                  chk("multi_no_valid", 16'(vld_cnt), 16'd1);
                  chk("multi_not_held", 16'(key_held), 16'h0);
        keys = 16'h0;

        // Bounce on row 2 col 1 for four ticks, then stable
        step(8);  chk("bounce_col", 16'(keyboard_col), 16'hD);
                  keys[9] = 1'b1;
        step(4);  keys[9] = 1'b0;
        step(4);  keys[9] = 1'b1;
        step(4);  keys[9] = 1'b0;
        step(4);  chk("bounce_col_kept", 16'(keyboard_col), 16'hD);
                  chk("bounce_no_valid", 16'(vld_cnt), 16'd1);
                  keys[9] = 1'b1;
        step(11); chk("bounce_e123_valid", 16'(key_valid), 16'h0);
        step(1);  chk("bounce_valid", 16'(key_valid), 16'h1);
                  chk("bounce_code",  16'(key_code),  16'h9);

        // Second key while held (same column -> multi, other column invisible)
        keys[1] = 1'b1; keys[7] = 1'b1;
        step(12); chk("second_no_valid", 16'(vld_cnt), 16'd2);
                  chk("second_held",     16'(key_held), 16'h1);
                  chk("second_col",      16'(keyboard_col), 16'hD);

        // Reset while held: no release pulse
        rst = 1'b1;
        #1;
        chk("rst_held_clr", 16'(key_held), 16'h0);
        chk("rst_col2",     16'(keyboard_col), 16'hE);
        chk("rst_code2",    16'(key_code), 16'h0);
        keys = 16'h0;
        step(2);
        chk("rst_no_release", 16'(rel_cnt), 16'd1);
        rst = 1'b0;

        // Key row 3 col 3: matched ticks at E16, E20, E24
        keys[15] = 1'b1;
        step(23); chk("k15_e23_valid", 16'(key_valid), 16'h0);
        step(1);  chk("k15_valid", 16'(key_valid), 16'h1);
                  chk("k15_code",  16'(key_code),  16'hF);
                  chk("k15_held",  16'(key_held),  16'h1);
        keys[15] = 1'b0;
        step(12); chk("k15_release", 16'(key_release), 16'h1);
                  chk("k15_held_clr", 16'(key_held), 16'h0);

        // Key row 0 col 0 after release: matched ticks at E44, E48, E52
        keys[0] = 1'b1;
        step(15); chk("k0_e51_valid", 16'(key_valid), 16'h0);
                  chk("k0_code_holds", 16'(key_code), 16'hF);
        step(1);  chk("k0_valid", 16'(key_valid), 16'h1);
                  chk("k0_code",  16'(key_code),  16'h0);
        step(1);  chk("k0_pulse_end", 16'(key_valid), 16'h0);
                  chk("k0_code_kept", 16'(key_code),  16'h0);
                  chk("final_vld_cnt", 16'(vld_cnt), 16'd4);
                  chk("final_rel_cnt", 16'(rel_cnt), 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
